mem_stage: RTL

- MEM stage of the 5-stage MIPS pipeline. It consumes the EX/MEM register outputs and owns the word-addressed data memory.
- Resolves branch, jump and jr redirects for the fetch stage.
- Registers the results into the MEM/WB pipeline register that feeds write-back.
- Sits between the EX/MEM register and the write-back mux.

---
 rtl/mem_stage_if.sv | 46 ++++
 rtl/mem_stage.sv | 108 ++++++++++
 2 files changed

// File: rtl/mem_stage_if.sv
// EX/MEM-to-MEM/WB bundle for the MEM stage: control and data from EX, redirect and
// MEM/WB results back out. The master drives the EX/MEM side; the stage is the slave.
interface mem_stage_if;
  logic [31:0] ALUResult_input;
  logic [31:0] ReadData2_input;
  logic [4:0]  WriteRegister_input;
  logic [31:0] PC_input;
  logic [31:0] PCPlus4_input;
  logic        Zero_input;
  logic        Jr_input;
  logic        Jal_input;
  logic        Jump_input;
  logic        BranchEQ_input;
  logic        BranchNE_input;
  logic        MemRead_input;
  logic        MemToReg_input;
  logic        MemWrite_input;
  logic        RegWrite_input;

  logic        pc_redirect;
  logic [31:0] pc_redirect_target;
  logic        mem_fault;
  logic [31:0] ReadData_output;
  logic [31:0] ALUResult_output;
  logic [31:0] PCPlus4_output;
  logic [4:0]  WriteRegister_output;
  logic        MemToReg_output;
  logic        RegWrite_output;
  logic        Jal_output;

  modport master (
    output ALUResult_input, ReadData2_input, WriteRegister_input, PC_input, PCPlus4_input,
           Zero_input, Jr_input, Jal_input, Jump_input, BranchEQ_input, BranchNE_input,
           MemRead_input, MemToReg_input, MemWrite_input, RegWrite_input,
    input  pc_redirect, pc_redirect_target, mem_fault, ReadData_output, ALUResult_output,
           PCPlus4_output, WriteRegister_output, MemToReg_output, RegWrite_output, Jal_output
  );

  modport slave (
    input  ALUResult_input, ReadData2_input, WriteRegister_input, PC_input, PCPlus4_input,
           Zero_input, Jr_input, Jal_input, Jump_input, BranchEQ_input, BranchNE_input,
           MemRead_input, MemToReg_input, MemWrite_input, RegWrite_input,
    output pc_redirect, pc_redirect_target, mem_fault, ReadData_output, ALUResult_output,
           PCPlus4_output, WriteRegister_output, MemToReg_output, RegWrite_output, Jal_output
  );
endinterface

// File: rtl/mem_stage.sv
// MIPS MEM stage: word-addressed data memory, branch/jump/jr redirect resolution and the
// MEM/WB pipeline register.
module mem_stage #(
  parameter int unsigned MEMORY_DEPTH = 64,
  parameter logic [31:0] DATA_BASE    = 32'h1001_0000
) (
  input logic        clk,
  input logic        reset,
  mem_stage_if.slave bus
);

  localparam int unsigned IdxW = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;

  logic [31:0] r_mem [MEMORY_DEPTH];

  logic [31:0]     w_offset;
  logic [31:0]     w_word;
  logic [IdxW-1:0] w_index;
  logic            w_misaligned;
  logic            w_out_of_range;
  logic            w_fault;
  logic [31:0]     w_rdata;
  logic            w_branch_taken;
  logic            w_redirect;
  logic [31:0]     w_target;

  logic        r_fault;
  logic [31:0] r_read_data;
  logic [31:0] r_alu_result;
  logic [31:0] r_pc_plus4;
  logic [4:0]  r_write_reg;
  logic        r_mem_to_reg;
  logic        r_reg_write;
  logic        r_jal;

  // Full word offset is kept so the range check sees every upper bit, not just the index.
  assign w_offset       = bus.ALUResult_input - DATA_BASE;
  assign w_word         = w_offset >> 2;
  assign w_index        = w_word[IdxW-1:0];
  assign w_misaligned   = bus.ALUResult_input[1:0] != 2'b00;
  assign w_out_of_range = (bus.ALUResult_input < DATA_BASE) || (w_word >= MEMORY_DEPTH);
  assign w_fault        = (bus.MemRead_input | bus.MemWrite_input) &
                          (w_misaligned | w_out_of_range);

  always_comb begin
    w_rdata = 32'h0;
    if (bus.MemRead_input && !w_fault) begin
      w_rdata = r_mem[w_index];
    end
  end

  assign w_branch_taken = (bus.BranchEQ_input & bus.Zero_input) |
                          (bus.BranchNE_input & ~bus.Zero_input);

  always_comb begin
    w_redirect = 1'b0;
    w_target   = bus.PCPlus4_input;
    if (bus.Jr_input) begin
      w_redirect = 1'b1;
      w_target   = bus.ALUResult_input;
    end else if (bus.Jump_input || w_branch_taken) begin
      w_redirect = 1'b1;
      w_target   = bus.PC_input;
    end
  end

  assign bus.pc_redirect        = w_redirect & ~reset;
  assign bus.pc_redirect_target = w_target;

  // Contents survive reset, so the array has no reset branch.
  always_ff @(posedge clk) begin
    if (bus.MemWrite_input && !w_fault && !reset) begin
      r_mem[w_index] <= bus.ReadData2_input;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fault      <= 1'b0;
      r_read_data  <= 32'h0;
      r_alu_result <= 32'h0;
      r_pc_plus4   <= 32'h0;
      r_write_reg  <= 5'd0;
      r_mem_to_reg <= 1'b0;
      r_reg_write  <= 1'b0;
      r_jal        <= 1'b0;
    end else begin
      r_fault      <= r_fault | w_fault;
      r_read_data  <= w_rdata;
      r_alu_result <= bus.ALUResult_input;
      r_pc_plus4   <= bus.PCPlus4_input;
      r_write_reg  <= bus.WriteRegister_input;
      r_mem_to_reg <= bus.MemToReg_input;
      r_reg_write  <= bus.RegWrite_input & ~(bus.MemRead_input & w_fault);
      r_jal        <= bus.Jal_input;
    end
  end

  assign bus.mem_fault            = r_fault;
  assign bus.ReadData_output      = r_read_data;
  assign bus.ALUResult_output     = r_alu_result;
  assign bus.PCPlus4_output       = r_pc_plus4;
  assign bus.WriteRegister_output = r_write_reg;
  assign bus.MemToReg_output      = r_mem_to_reg;
  assign bus.RegWrite_output      = r_reg_write;
  assign bus.Jal_output           = r_jal;

endmodule
